// File: rtl/gem_trigger_link_rx.sv
// GEM trigger fiber link receiver: aligns 4-word frames on the word-0 comma, rebuilds the 56-bit
// cluster payload, tracks link lock and the latency-marker period, and keeps saturating error counts.
module gem_trigger_link_rx #(
  parameter int unsigned LOCK_FRAMES   = 8,
  parameter int unsigned MAX_MISS      = 4,
  parameter int unsigned MARKER_PERIOD = 128,
  parameter int unsigned ERR_CNT_W     = 16
) (
  input  logic                 clk_160_i,
  input  logic                 reset_n_i,
  input  logic [15:0]          rx_data_i,
  input  logic [1:0]           rx_charisk_i,
  input  logic [1:0]           rx_disperr_i,
  input  logic [1:0]           rx_notintable_i,
  input  logic                 err_cnt_clr_i,
  output logic [13:0]          cluster0_o,
  output logic [13:0]          cluster1_o,
  output logic [13:0]          cluster2_o,
  output logic [13:0]          cluster3_o,
  output logic                 overflow_o,
  output logic                 frame_valid_o,
  output logic                 marker_o,
  output logic                 locked_o,
  output logic                 marker_err_o,
  output logic [ERR_CNT_W-1:0] frame_err_cnt_o,
  output logic [ERR_CNT_W-1:0] marker_err_cnt_o
);

  localparam int unsigned LockW = $clog2(LOCK_FRAMES + 1);
  localparam int unsigned MissW = $clog2(MAX_MISS + 1);
  localparam int unsigned MkW   = $clog2(MARKER_PERIOD + 1);

  typedef enum logic [1:0] {StUnlocked, StAligning, StLocked} state_e;

  state_e           state_q;
  logic [1:0]       wcnt_q;
  logic [LockW-1:0] good_cnt_q;
  logic [MissW-1:0] miss_cnt_q;
  logic             mk_active_q;
  logic [MkW-1:0]   mk_cnt_q;
  logic [39:0]      pay_q;
  logic             ovf_q;
  logic             mk_q;
  logic             bad_q;

  logic        word_err;
  logic        word_bad;
  logic        comma_ok;
  logic        comma_ovf;
  logic        comma_mk;
  logic        frame_good;
  logic        frame_mk;
  logic        mk_due;
  logic [55:0] frame_pay;

  always_comb begin
    word_err  = |{rx_disperr_i, rx_notintable_i};
    word_bad  = word_err | (|rx_charisk_i);
    comma_ok  = 1'b0;
    comma_ovf = 1'b0;
    comma_mk  = 1'b0;
    if (rx_charisk_i == 2'b01 && !word_err) begin
      case (rx_data_i[7:0])
        8'hBC: comma_ok = 1'b1;
        8'hF7: begin comma_ok = 1'b1; comma_ovf = 1'b1; end
        8'hFC: begin comma_ok = 1'b1; comma_mk = 1'b1; end
        8'hFB: begin comma_ok = 1'b1; comma_ovf = 1'b1; comma_mk = 1'b1; end
        default: ;
      endcase
    end
    // Only meaningful while word 3 is on the input.
    frame_good = !bad_q && !word_bad;
    frame_mk   = frame_good && mk_q;
    mk_due     = (mk_cnt_q == MkW'(MARKER_PERIOD - 1));
    frame_pay  = {rx_data_i, pay_q};
  end

  always_ff @(posedge clk_160_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q          <= StUnlocked;
      wcnt_q           <= 2'd0;
      good_cnt_q       <= '0;
      miss_cnt_q       <= '0;
      mk_active_q      <= 1'b0;
      mk_cnt_q         <= '0;
      pay_q            <= '0;
      ovf_q            <= 1'b0;
      mk_q             <= 1'b0;
      bad_q            <= 1'b0;
      cluster0_o       <= '0;
      cluster1_o       <= '0;
      cluster2_o       <= '0;
      cluster3_o       <= '0;
      overflow_o       <= 1'b0;
      frame_valid_o    <= 1'b0;
      marker_o         <= 1'b0;
      locked_o         <= 1'b0;
      marker_err_o     <= 1'b0;
      frame_err_cnt_o  <= '0;
      marker_err_cnt_o <= '0;
    end else begin
      wcnt_q        <= wcnt_q + 2'd1;
      frame_valid_o <= 1'b0;
      marker_o      <= 1'b0;
      marker_err_o  <= 1'b0;
      if (state_q == StUnlocked) begin
        // Any clean comma is taken as word 0 and starts the first candidate frame.
        if (comma_ok) begin
          state_q    <= StAligning;
          wcnt_q     <= 2'd1;
          good_cnt_q <= '0;
          pay_q[7:0] <= rx_data_i[15:8];
          ovf_q      <= comma_ovf;
          mk_q       <= comma_mk;
          bad_q      <= 1'b0;
        end
      end else begin
        unique case (wcnt_q)
          2'd0: begin
            pay_q[7:0] <= rx_data_i[15:8];
            ovf_q      <= comma_ovf;
            mk_q       <= comma_mk;
            bad_q      <= !comma_ok;
          end
          2'd1: begin
            pay_q[23:8] <= rx_data_i;
            bad_q       <= bad_q | word_bad;
          end
          2'd2: begin
            pay_q[39:24] <= rx_data_i;
            bad_q        <= bad_q | word_bad;
          end
          2'd3: begin
            if (state_q == StAligning) begin
              if (!frame_good) begin
                state_q <= StUnlocked;
              end else if (good_cnt_q == LockW'(LOCK_FRAMES - 1)) begin
                state_q       <= StLocked;
                locked_o      <= 1'b1;
                miss_cnt_q    <= '0;
                mk_active_q   <= 1'b0;
                mk_cnt_q      <= '0;
                frame_valid_o <= 1'b1;
                marker_o      <= mk_q;
                overflow_o    <= ovf_q;
                cluster0_o    <= frame_pay[13:0];
                cluster1_o    <= frame_pay[27:14];
                cluster2_o    <= frame_pay[41:28];
                cluster3_o    <= frame_pay[55:42];
              end else begin
                good_cnt_q <= good_cnt_q + LockW'(1);
              end
            end else begin
              // Marker period tracking; cleared below if this frame drops lock.
              if (!mk_active_q) begin
                if (frame_mk) begin
                  mk_active_q <= 1'b1;
                  mk_cnt_q    <= '0;
                end
              end else if (frame_mk || mk_due) begin
                mk_cnt_q <= '0;
                if (!(frame_mk && mk_due)) begin
                  marker_err_o <= 1'b1;
                  if (marker_err_cnt_o != '1) begin
                    marker_err_cnt_o <= marker_err_cnt_o + ERR_CNT_W'(1);
                  end
                end
              end else begin
                mk_cnt_q <= mk_cnt_q + MkW'(1);
              end
              if (frame_good) begin
                miss_cnt_q    <= '0;
                frame_valid_o <= 1'b1;
                marker_o      <= mk_q;
                overflow_o    <= ovf_q;
                cluster0_o    <= frame_pay[13:0];
                cluster1_o    <= frame_pay[27:14];
                cluster2_o    <= frame_pay[41:28];
                cluster3_o    <= frame_pay[55:42];
              end else begin
                if (frame_err_cnt_o != '1) begin
                  frame_err_cnt_o <= frame_err_cnt_o + ERR_CNT_W'(1);
                end
                if (miss_cnt_q == MissW'(MAX_MISS - 1)) begin
                  state_q     <= StUnlocked;
                  locked_o    <= 1'b0;
                  miss_cnt_q  <= '0;
                  mk_active_q <= 1'b0;
                  mk_cnt_q    <= '0;
                end else begin
                  miss_cnt_q <= miss_cnt_q + MissW'(1);
                end
              end
            end
          end
        endcase
      end
      if (err_cnt_clr_i) begin
        frame_err_cnt_o  <= '0;
        marker_err_cnt_o <= '0;
      end
    end
  end

endmodule
